simplez_ctrl: RTL and testbench
===============================

# simplez_ctrl

Control unit for the Simplez CPU. It drives every microorder that sequences the separate datapath (CP, RA, RI, AC, ALU, memory), taking as inputs only the RI opcode field and the AC zero flag. It runs the full Simplez instruction set (ST, LD, ADD, BR, BZ, CLR, DEC, HALT) and halts with `stop`.

## Interface
- No parameters. Opcode, state and ALU-op encodings are fixed in the shared package.
- `clk` in 1: system clock. The state register updates on the negedge. The datapath registers update on the posedge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `op` in 3: opcode, RI[11:9]. ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7.
- `z` in 1: 1 when AC==0.
- `lec`, `esc` out 1: memory read / write.
- `era` out 1: load RA from the internal address bus.
- `incp`, `ecp`, `ccp`, `scp` out 1: CP increment / load from bus / clear / drive bus.
- `eri`, `sri` out 1: load RI from the data bus / drive the RI CD field onto the address bus.
- `eac`, `sac` out 1: load AC from the ALU / drive AC onto the data bus.
- `alu_op` out 2: PASS=0 (data bus), ADD=1, CLR=2, DEC=3.
- `stop` out 1: processor halted.

## Operation
- States: INIT, I0, I1, O0, O1, HLT. Encoding is 3-bit, from the package.
- Outputs are combinational from (state, op, z).
- Defaults are all 0 and `alu_op`=PASS.
- INIT asserts `ccp` (CP←0). Next state is O1.
- O1 asserts `scp`, `era` (RA←CP). Next state is I0.
- I0 (fetch) asserts `lec`, `eri`, `incp`. Next state is I1.
- I1 (decode/execute), by `op`:
  - ST, LD, ADD: `sri`, `era` (RA←CD). Next state is O0.
  - BR: `sri`, `ecp`, `era` (CP←CD, RA←CD). Next state is I0.
  - BZ with z=1: same as BR.
  - BZ with z=0: `scp`, `era`. Next state is I0.
  - CLR: `eac`, alu_op=CLR, `scp`, `era`. Next state is I0.
  - DEC: `eac`, alu_op=DEC, `scp`, `era`. Next state is I0.
  - HALT: no microorders. Next state is HLT.
- O0, by the opcode latched in RI:
  - ST: `sac`, `esc`.
  - LD: `lec`, `eac`, alu_op=PASS.
  - ADD: `lec`, `eac`, alu_op=ADD.
  - Next state is O1 in all three cases.
- HLT: `stop`=1. Stays in HLT until `rst`.
- Illegal state encoding: next state is INIT.
- Mutual exclusion: `lec` and `esc` are never both 1. At most one of `scp`/`sri` drives the address bus. At most one of `sac`/`lec` drives the data bus.

## Timing
- `rst` high forces state=INIT immediately. All outputs except `ccp` read 0 while `rst` is high.
- Reset asserted mid-instruction aborts it. Any half-done write (`esc` in O0) is dropped when the state leaves O0.
- After `rst` falls, the first fetch (I0) is the 3rd negedge-bounded state (INIT, O1, I0). It reads address 0.
- Cycles per instruction, counted I0..next I0:
  - ST, LD, ADD: 4 (I0, I1, O0, O1).
  - BR, BZ, CLR, DEC: 2.
- `op` and `z` are sampled only during I1 and O0. They must be stable from the posedge preceding each state's negedge exit.
- `z` reflects AC after the previous instruction has completed.
- `stop` rises at the negedge that enters HLT: 2 cycles after HALT's I0 begins.

## Configuration
- `SIMPLEZ_STEP_EN` defined:
  - Adds input `step` (1 bit, synchronous, one-cycle pulse) and state WAIT.
  - Every transition that targets I0 goes to WAIT instead.
  - WAIT has all outputs 0 and moves to I0 at a negedge where `step`=1.
  - Result: one instruction per pulse.
- Undefined: no `step` port, no WAIT state. Free-running.

## Structure
- Package `simplez_pkg`: opcode localparams (ST..HALT), state encodings (INIT, I0, I1, O0, O1, HLT, WAIT), alu_op codes, DATAW=12, ADDRW=9.
- Sub-module `simplez_ctrl_decode`: purely combinational (state, op, z) → microorder vector. Checkable in isolation against the Operation rules.
- `simplez_ctrl` holds only the state register and the next-state logic.

## Test plan
- Pulse `rst`, then run with op=HALT. Required sequence: INIT (`ccp`=1), O1 (`scp`, `era`), I0 (`lec`, `eri`, `incp`), I1, then `stop`=1 held for 20+ cycles.
- op=LD. Required: I1 `sri`+`era`; O0 `lec`+`eac` with alu_op=0; O1 `scp`+`era`; back to I0 after exactly 4 cycles. Same check for ADD with alu_op=1, and for ST with `sac`+`esc`, `lec`=0.
- op=BZ with z=1, then z=0. Required: z=1 gives I1 `ecp`+`sri`+`era`; z=0 gives `scp`+`era`, `ecp`=0. Both return to I0 in 2 cycles.
- op=DEC, then op=CLR. Required: I1 `eac`=1 with alu_op=3, then 2. Next state is I0.
- Assert `rst` during O0 of ST. Required: `esc` drops to 0 asynchronously, state=INIT. After release, the first I0 occurs 2 cycles later.
- With `SIMPLEZ_STEP_EN` defined and `step`=0: required to hold WAIT with all outputs 0 for 10 cycles. A single `step` pulse executes exactly one BR (I0, I1), then returns to WAIT.

Source files
------------

// File: rtl/simplez_pkg.sv
// simplez_pkg -- shared encodings for the Simplez control unit.
//   Opcodes (RI[11:9]), control-unit state encodings, ALU operation codes,
//   datapath widths and the microorder bundle produced by the decoder.
//   The WAIT state is always encoded; it is only reachable when the
//   control unit is built with SIMPLEZ_STEP_EN.
package simplez_pkg;

   localparam int DATAW = 12;
   localparam int ADDRW = 9;

   // Opcode field of RI
   localparam logic [2:0] OP_ST   = 3'd0;
   localparam logic [2:0] OP_LD   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_BR   = 3'd3;
   localparam logic [2:0] OP_BZ   = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_DEC  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   // ALU operations
   localparam logic [1:0] ALU_PASS = 2'd0;
   localparam logic [1:0] ALU_ADD  = 2'd1;
   localparam logic [1:0] ALU_CLR  = 2'd2;
   localparam logic [1:0] ALU_DEC  = 2'd3;

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_I0   = 3'd1,
      ST_I1   = 3'd2,
      ST_O0   = 3'd3,
      ST_O1   = 3'd4,
      ST_HLT  = 3'd5,
      ST_WAIT = 3'd6
   } state_t;

   // Every microorder the control unit can issue in one cycle.
   typedef struct packed {
      logic       lec;
      logic       esc;
      logic       era;
      logic       incp;
      logic       ecp;
      logic       ccp;
      logic       scp;
      logic       eri;
      logic       sri;
      logic       eac;
      logic       sac;
      logic [1:0] alu_op;
      logic       stop;
   } mo_t;

   // True for the opcodes that need an operand cycle (O0).
   function automatic logic is_mem_op(input logic [2:0] op);
      return (op == OP_ST) || (op == OP_LD) || (op == OP_ADD);
   endfunction

endpackage

// File: rtl/simplez_ctrl_if.sv
// simplez_ctrl_if -- control-unit <-> datapath bundle.
//   Datapath -> control: op (RI[11:9]), z (AC==0), step (SIMPLEZ_STEP_EN only).
//   Control -> datapath: lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac,
//   sac, alu_op, stop.
//   modport master: the control unit.  modport slave: the datapath side.
//   Optional macro: SIMPLEZ_STEP_EN adds the step input.
interface simplez_ctrl_if;

   logic [2:0] op;
   logic       z;
`ifdef SIMPLEZ_STEP_EN
   logic       step;
`endif
   logic       lec;
   logic       esc;
   logic       era;
   logic       incp;
   logic       ecp;
   logic       ccp;
   logic       scp;
   logic       eri;
   logic       sri;
   logic       eac;
   logic       sac;
   logic [1:0] alu_op;
   logic       stop;

`ifdef SIMPLEZ_STEP_EN
   modport master (
      input  op, z, step,
      output lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac, alu_op, stop
   );
   modport slave (
      output op, z, step,
      input  lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac, alu_op, stop
   );
`else
   modport master (
      input  op, z,
      output lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac, alu_op, stop
   );
   modport slave (
      output op, z,
      input  lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac, alu_op, stop
   );
`endif

endinterface

// File: rtl/simplez_ctrl_decode.sv
// simplez_ctrl_decode -- purely combinational microorder decoder.
//   Ports: state (current control state), op (RI opcode), z (AC==0 flag),
//          mo (microorder bundle for this cycle).
//   Any state without listed microorders (WAIT, illegal codes) drives all 0.
module simplez_ctrl_decode
   import simplez_pkg::*;
(
   input  state_t     state,
   input  logic [2:0] op,
   input  logic       z,
   output mo_t        mo
);

   always_comb begin
      mo        = '0;
      mo.alu_op = ALU_PASS;
      case (state)
         ST_INIT: begin
            mo.ccp = 1'b1;
         end
         ST_O1: begin
            // RA <- CP: address of the next instruction
            mo.scp = 1'b1;
            mo.era = 1'b1;
         end
         ST_I0: begin
            // RI <- M[RA], CP <- CP+1
            mo.lec  = 1'b1;
            mo.eri  = 1'b1;
            mo.incp = 1'b1;
         end
         ST_I1: begin
            case (op)
               OP_ST, OP_LD, OP_ADD: begin
                  mo.sri = 1'b1;
                  mo.era = 1'b1;
               end
               OP_BR: begin
                  mo.sri = 1'b1;
                  mo.ecp = 1'b1;
                  mo.era = 1'b1;
               end
               OP_BZ: begin
                  if (z) begin
                     mo.sri = 1'b1;
                     mo.ecp = 1'b1;
                     mo.era = 1'b1;
                  end else begin
                     mo.scp = 1'b1;
                     mo.era = 1'b1;
                  end
               end
               OP_CLR: begin
                  mo.eac    = 1'b1;
                  mo.alu_op = ALU_CLR;
                  mo.scp    = 1'b1;
                  mo.era    = 1'b1;
               end
               OP_DEC: begin
                  mo.eac    = 1'b1;
                  mo.alu_op = ALU_DEC;
                  mo.scp    = 1'b1;
                  mo.era    = 1'b1;
               end
               default: begin
                  // HALT: nothing this cycle
               end
            endcase
         end
         ST_O0: begin
            case (op)
               OP_ST: begin
                  mo.sac = 1'b1;
                  mo.esc = 1'b1;
               end
               OP_LD: begin
                  mo.lec    = 1'b1;
                  mo.eac    = 1'b1;
                  mo.alu_op = ALU_PASS;
               end
               OP_ADD: begin
                  mo.lec    = 1'b1;
                  mo.eac    = 1'b1;
                  mo.alu_op = ALU_ADD;
               end
               default: begin
                  // not reachable: only memory opcodes enter O0
               end
            endcase
         end
         ST_HLT: begin
            mo.stop = 1'b1;
         end
         default: begin
            // WAIT and illegal encodings: all microorders idle
         end
      endcase
   end

endmodule

// File: rtl/simplez_ctrl.sv
// simplez_ctrl -- Simplez CPU control unit (state register + next state).
//   Ports: clk  system clock; the state register advances on the falling
//               edge so microorders are stable around the datapath's
//               rising edge.
//          rst  asynchronous, active-high; forces INIT immediately.
//          bus  simplez_ctrl_if.master: op/z (and step) in, microorders out.
//   Optional macro: SIMPLEZ_STEP_EN -- single-step mode; every transition
//   toward I0 parks in WAIT until a step pulse is seen at a falling edge.
module simplez_ctrl
   import simplez_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   simplez_ctrl_if.master bus
);

`ifdef SIMPLEZ_STEP_EN
   localparam state_t FETCH_TGT = ST_WAIT;
`else
   localparam state_t FETCH_TGT = ST_I0;
`endif

   state_t state_reg;
   state_t state_next;
   mo_t    mo;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_INIT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = ST_INIT;
      case (state_reg)
         ST_INIT: state_next = ST_O1;
         ST_O1:   state_next = FETCH_TGT;
         ST_I0:   state_next = ST_I1;
         ST_I1: begin
            if (is_mem_op(bus.op)) begin
               state_next = ST_O0;
            end else if (bus.op == OP_HALT) begin
               state_next = ST_HLT;
            end else begin
               state_next = FETCH_TGT;
            end
         end
         ST_O0:   state_next = ST_O1;
         ST_HLT:  state_next = ST_HLT;
`ifdef SIMPLEZ_STEP_EN
         ST_WAIT: state_next = bus.step ? ST_I0 : ST_WAIT;
`endif
         default: state_next = ST_INIT;
      endcase
   end

   simplez_ctrl_decode u_decode (
      .state (state_reg),
      .op    (bus.op),
      .z     (bus.z),
      .mo    (mo)
   );

   assign bus.lec    = mo.lec;
   assign bus.esc    = mo.esc;
   assign bus.era    = mo.era;
   assign bus.incp   = mo.incp;
   assign bus.ecp    = mo.ecp;
   assign bus.ccp    = mo.ccp;
   assign bus.scp    = mo.scp;
   assign bus.eri    = mo.eri;
   assign bus.sri    = mo.sri;
   assign bus.eac    = mo.eac;
   assign bus.sac    = mo.sac;
   assign bus.alu_op = mo.alu_op;
   assign bus.stop   = mo.stop;

endmodule

// File: tb/tb_simplez_ctrl.sv
// tb_simplez_ctrl -- directed bench for simplez_ctrl.
//   Walks the control unit through boot, every instruction class, a reset
//   during a store, and (with SIMPLEZ_STEP_EN) single-step mode. Outputs are
//   sampled 1 time unit after each rising edge, mid-way through the state
//   entered at the preceding falling edge.
module tb_simplez_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   simplez_ctrl_if bus ();

   simplez_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {lec,esc,era,incp,ecp,ccp,scp,eri,sri,eac,sac,alu_op,stop}
   logic [13:0] obs;
   assign obs = {bus.lec, bus.esc, bus.era, bus.incp, bus.ecp, bus.ccp,
                 bus.scp, bus.eri, bus.sri, bus.eac, bus.sac, bus.alu_op,
                 bus.stop};

   function automatic logic [13:0] mo(
      input logic lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac,
      input logic [1:0] alu,
      input logic stp);
      return {lec, esc, era, incp, ecp, ccp, scp, eri, sri, eac, sac, alu, stp};
   endfunction

   logic [13:0] m_zero, m_init, m_o1, m_i0, m_i1_mem, m_br, m_bz0;
   logic [13:0] m_clr, m_dec, m_st_o0, m_ld_o0, m_add_o0, m_hlt;

   task automatic check(input string tag, input logic [13:0] got,
                        input logic [13:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end else begin
         $display("ok   %s: %b", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance into I0 from O1 / a short instruction and check the fetch.
   task automatic enter_i0(input string tag);
`ifdef SIMPLEZ_STEP_EN
      tick();
      check({tag, "_wait"}, obs, m_zero);
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
`else
      tick();
`endif
      check({tag, "_i0"}, obs, m_i0);
   endtask

   task automatic restart(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_init"}, obs, m_init);
      tick();
      rst = 1'b0;
      tick();
      check({tag, "_o1"}, obs, m_o1);
      enter_i0(tag);
   endtask

   // Memory-reference instruction starting from a sampled I0.
   task automatic run4(input string tag, input logic [2:0] op,
                       input logic [13:0] exp_o0);
      bus.op = op;
      tick();
      check({tag, "_i1"}, obs, m_i1_mem);
      tick();
      check({tag, "_o0"}, obs, exp_o0);
      tick();
      check({tag, "_o1"}, obs, m_o1);
      enter_i0(tag);
   endtask

   // Two-cycle instruction starting from a sampled I0.
   task automatic run2(input string tag, input logic [2:0] op, input logic zv,
                       input logic [13:0] exp_i1);
      bus.op = op;
      bus.z  = zv;
      tick();
      check({tag, "_i1"}, obs, exp_i1);
      enter_i0(tag);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_zero   = '0;
      m_init   = mo(0,0,0,0,0,1,0,0,0,0,0,2'd0,0);
      m_o1     = mo(0,0,1,0,0,0,1,0,0,0,0,2'd0,0);
      m_i0     = mo(1,0,0,1,0,0,0,1,0,0,0,2'd0,0);
      m_i1_mem = mo(0,0,1,0,0,0,0,0,1,0,0,2'd0,0);
      m_br     = mo(0,0,1,0,1,0,0,0,1,0,0,2'd0,0);
      m_bz0    = mo(0,0,1,0,0,0,1,0,0,0,0,2'd0,0);
      m_clr    = mo(0,0,1,0,0,0,1,0,0,1,0,2'd2,0);
      m_dec    = mo(0,0,1,0,0,0,1,0,0,1,0,2'd3,0);
      m_st_o0  = mo(0,1,0,0,0,0,0,0,0,0,1,2'd0,0);
      m_ld_o0  = mo(1,0,0,0,0,0,0,0,0,1,0,2'd0,0);
      m_add_o0 = mo(1,0,0,0,0,0,0,0,0,1,0,2'd1,0);
      m_hlt    = mo(0,0,0,0,0,0,0,0,0,0,0,2'd0,1);

      rst    = 1'b1;
      bus.op = 3'd7;
      bus.z  = 1'b0;
`ifdef SIMPLEZ_STEP_EN
      bus.step = 1'b0;
`endif

      // Boot straight into HALT
      tick();
      check("boot_rst_init", obs, m_init);
      rst = 1'b0;
      tick();
      check("boot_o1", obs, m_o1);
      enter_i0("boot");
      tick();
      check("halt_i1", obs, m_zero);
      for (int i = 0; i < 22; i++) begin
         tick();
         check("halt_stop", obs, m_hlt);
      end

      // Memory-reference instructions
      restart("rs1");
      run4("ld", 3'd1, m_ld_o0);
      run4("add", 3'd2, m_add_o0);
      run4("st", 3'd0, m_st_o0);

      // Two-cycle instructions
      run2("bz1", 3'd4, 1'b1, m_br);
      run2("bz0", 3'd4, 1'b0, m_bz0);
      run2("dec", 3'd6, 1'b0, m_dec);
      run2("clr", 3'd5, 1'b1, m_clr);
      run2("br", 3'd3, 1'b0, m_br);

      // Reset during the store's O0 must drop esc at once
      bus.op = 3'd0;
      tick();
      check("rst_st_i1", obs, m_i1_mem);
      tick();
      check("rst_st_o0", obs, m_st_o0);
      rst = 1'b1;
      #1;
      check("rst_abort", obs, m_init);
      tick();
      check("rst_hold", obs, m_init);
      rst = 1'b0;
      tick();
      check("rst_o1", obs, m_o1);
      enter_i0("rst");

`ifdef SIMPLEZ_STEP_EN
      // Parked in WAIT with no step pulse
      bus.op = 3'd3;
      tick();
      check("step_i1", obs, m_br);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("step_idle", obs, m_zero);
      end
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      check("step_i0", obs, m_i0);
      tick();
      check("step_br_i1", obs, m_br);
      tick();
      check("step_back_wait", obs, m_zero);
      tick();
      check("step_still_wait", obs, m_zero);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
